// File: rtl/xadc_drp_writer.sv
// DRP write initiator: one register write per request, optional read-back verify, drdy timeout.
// Latency: accept c0, den c1, resp_valid one cycle after the accepted drdy (or after timeout).
// Backpressure: req_ready only in IDLE; the response is a single pulse with no backpressure.
module xadc_drp_writer #(
    parameter int unsigned TIMEOUT     = 255,
    parameter logic [15:0] VERIFY_MASK = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_addr,
    input  logic [15:0] req_data,
    input  logic        req_verify,
    output logic        den,
    output logic        dwe,
    output logic [6:0]  daddr,
    output logic [15:0] di,
    input  logic [15:0] do_in,
    input  logic        drdy,
    output logic        busy,
    output logic        resp_valid,
    output logic [1:0]  resp_status,
    output logic [15:0] resp_rdata
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_WR_WAIT = 3'd2,
        S_RD      = 3'd3,
        S_RD_WAIT = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    localparam logic [1:0]  ST_OK       = 2'b00;
    localparam logic [1:0]  ST_TIMEOUT  = 2'b01;
    localparam logic [1:0]  ST_MISMATCH = 2'b10;
    // Compared against the incremented count, so one extra bit avoids wrap at 16'hFFFF.
    localparam logic [16:0] TIMEOUT_L   = 17'(TIMEOUT);

    state_t      state_q, state_d;
    logic [6:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        verify_q, verify_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  status_q, status_d;
    logic [15:0] rdata_q, rdata_d;

    logic [16:0] cnt_next;
    logic [15:0] cnt_sat;
    logic        limit_hit;
    logic        rd_match;

    // Wait-state bookkeeping: the limit fires on the cycle the counter would reach TIMEOUT.
    always_comb begin
        cnt_next  = {1'b0, cnt_q} + 17'd1;
        cnt_sat   = (&cnt_q) ? cnt_q : cnt_next[15:0];
        limit_hit = (cnt_next >= TIMEOUT_L);
        rd_match  = (((do_in ^ data_q) & VERIFY_MASK) == 16'h0000);
    end

    // Next-state and Moore outputs; drdy is only looked at in the two wait states.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        verify_d   = verify_q;
        cnt_d      = cnt_q;
        status_d   = status_q;
        rdata_d    = rdata_q;
        req_ready  = 1'b0;
        den        = 1'b0;
        dwe        = 1'b0;
        resp_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Gated by rstn so the port reads 0 while reset is held.
                req_ready = rstn;
                if (req_valid && rstn) begin
                    addr_d   = req_addr;
                    data_d   = req_data;
                    verify_d = req_verify;
                    state_d  = S_WR;
                end
            end
            S_WR: begin
                den     = 1'b1;
                dwe     = 1'b1;
                cnt_d   = 16'h0000;
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                cnt_d = cnt_sat;
                if (drdy) begin
                    if (verify_q) begin
                        state_d = S_RD;
                    end else begin
                        status_d = ST_OK;
                        rdata_d  = 16'h0000;
                        state_d  = S_RESP;
                    end
                end else if (limit_hit) begin
                    status_d = ST_TIMEOUT;
                    rdata_d  = 16'h0000;
                    state_d  = S_RESP;
                end
            end
            S_RD: begin
                den     = 1'b1;
                cnt_d   = 16'h0000;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                cnt_d = cnt_sat;
                if (drdy) begin
                    rdata_d  = do_in;
                    status_d = rd_match ? ST_OK : ST_MISMATCH;
                    state_d  = S_RESP;
                end else if (limit_hit) begin
                    status_d = ST_TIMEOUT;
                    rdata_d  = 16'h0000;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            addr_q   <= 7'h00;
            data_q   <= 16'h0000;
            verify_q <= 1'b0;
            cnt_q    <= 16'h0000;
            status_q <= 2'b00;
            rdata_q  <= 16'h0000;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            verify_q <= verify_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            rdata_q  <= rdata_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign daddr       = addr_q;
    assign di          = data_q;
    assign resp_status = status_q;
    assign resp_rdata  = rdata_q;

endmodule

// File: tb/tb_xadc_drp_writer.sv
// Bench for xadc_drp_writer: two instances (VERIFY_MASK FFFF and FFFE) share one DRP responder.
// A transaction-level model predicts each cycle's outputs from the accept cycle and drdy delays.
// Literal expectations pin latency, status and read-back data for the directed cases.
module tb_xadc_drp_writer;

    localparam int TO    = 8;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_verify = 1'b0;
    logic [6:0]  req_addr = 7'h00;
    logic [15:0] req_data = 16'h0000;
    logic [15:0] do_in = 16'h0000;
    logic        drdy = 1'b0;

    logic        req_ready_w [2];
    logic        den_w       [2];
    logic        dwe_w       [2];
    logic        busy_w      [2];
    logic        rv_w        [2];
    logic [6:0]  daddr_w     [2];
    logic [15:0] di_w        [2];
    logic [15:0] rdata_w     [2];
    logic [1:0]  st_w        [2];

    xadc_drp_writer #(.TIMEOUT(TO), .VERIFY_MASK(16'hFFFF)) u0 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready_w[0]),
        .req_addr(req_addr), .req_data(req_data), .req_verify(req_verify),
        .den(den_w[0]), .dwe(dwe_w[0]), .daddr(daddr_w[0]), .di(di_w[0]),
        .do_in(do_in), .drdy(drdy), .busy(busy_w[0]), .resp_valid(rv_w[0]),
        .resp_status(st_w[0]), .resp_rdata(rdata_w[0])
    );

    xadc_drp_writer #(.TIMEOUT(TO), .VERIFY_MASK(16'hFFFE)) u1 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready_w[1]),
        .req_addr(req_addr), .req_data(req_data), .req_verify(req_verify),
        .den(den_w[1]), .dwe(dwe_w[1]), .daddr(daddr_w[1]), .di(di_w[1]),
        .do_in(do_in), .drdy(drdy), .busy(busy_w[1]), .resp_valid(rv_w[1]),
        .resp_status(st_w[1]), .resp_rdata(rdata_w[1])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // Transaction model: cycle numbers of the interesting events for the current request.
    bit          act = 1'b0;
    int          m_acc = 0, m_wr = -1, m_rd = -1, m_resp = -1;
    logic [6:0]  m_addr = 7'h00;
    logic [15:0] m_data = 16'h0000;
    logic [15:0] m_rdata = 16'h0000;
    logic [1:0]  m_status [2];

    int          dly_wr = 1, dly_rd = 1;
    logic [15:0] rd_val = 16'h0000;
    int          drdy_at = -1;

    int          last_resp [2];
    logic [1:0]  last_st   [2];
    logic [15:0] last_rd   [2];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    // DRP responder: drdy one pulse 'delay' cycles after each den seen on instance 0.
    always @(posedge clk) begin
        int dl;
        #1;
        drdy  = (cyc == drdy_at);
        do_in = drdy ? rd_val : 16'hDEAD;
        if (den_w[0] === 1'b1) begin
            dl      = (dwe_w[0] === 1'b1) ? dly_wr : dly_rd;
            drdy_at = (dl >= NEVER) ? -1 : cyc + dl;
        end
    end

    // Every-cycle compare of both instances against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic busy_e, rdy_e, den_e, dwe_e, rv_e;
            busy_e = rstn && act && (cyc > m_acc) && (cyc <= m_resp);
            rdy_e  = rstn && !busy_e;
            den_e  = busy_e && ((cyc == m_wr) || (cyc == m_rd));
            dwe_e  = busy_e && (cyc == m_wr);
            rv_e   = busy_e && (cyc == m_resp);
            chk($sformatf("busy[%0d] c%0d", d, cyc), busy_w[d], busy_e);
            chk($sformatf("req_ready[%0d] c%0d", d, cyc), req_ready_w[d], rdy_e);
            chk($sformatf("den[%0d] c%0d", d, cyc), den_w[d], den_e);
            chk($sformatf("dwe[%0d] c%0d", d, cyc), dwe_w[d], dwe_e);
            chk($sformatf("resp_valid[%0d] c%0d", d, cyc), rv_w[d], rv_e);
            if (!rstn) begin
                chk($sformatf("rst daddr[%0d]", d), daddr_w[d], 0);
                chk($sformatf("rst di[%0d]", d), di_w[d], 0);
                chk($sformatf("rst status[%0d]", d), st_w[d], 0);
                chk($sformatf("rst rdata[%0d]", d), rdata_w[d], 0);
            end
            if (busy_e) begin
                chk($sformatf("daddr[%0d] c%0d", d, cyc), daddr_w[d], m_addr);
                chk($sformatf("di[%0d] c%0d", d, cyc), di_w[d], m_data);
            end
            if (rv_e) begin
                chk($sformatf("status[%0d] c%0d", d, cyc), st_w[d], m_status[d]);
                chk($sformatf("rdata[%0d] c%0d", d, cyc), rdata_w[d], m_rdata);
            end
            if (rv_w[d] === 1'b1) begin
                last_resp[d] = cyc;
                last_st[d]   = st_w[d];
                last_rd[d]   = rdata_w[d];
            end
        end
    end

    // Load the model for a request accepted in the current cycle.
    task automatic model_start(input logic [6:0] a, input logic [15:0] dt, input bit v,
                               input int dw, input int dr, input logic [15:0] rv);
        int t;
        m_acc  = cyc;
        m_addr = a;
        m_data = dt;
        m_wr   = cyc + 1;
        m_rd   = -1;
        m_rdata = 16'h0000;
        if (dw <= TO) begin
            t = cyc + 2 + dw;
            if (v) begin
                m_rd = t;
                if (dr <= TO) begin
                    m_resp  = t + 1 + dr;
                    m_rdata = rv;
                    m_status[0] = ((rv ^ dt) == 16'h0000) ? 2'b00 : 2'b10;
                    m_status[1] = (((rv ^ dt) & 16'hFFFE) == 16'h0000) ? 2'b00 : 2'b10;
                end else begin
                    m_resp = t + 1 + TO;
                    m_status[0] = 2'b01;
                    m_status[1] = 2'b01;
                end
            end else begin
                m_resp = t;
                m_status[0] = 2'b00;
                m_status[1] = 2'b00;
            end
        end else begin
            m_resp = cyc + 2 + TO;
            m_status[0] = 2'b01;
            m_status[1] = 2'b01;
        end
        act = 1'b1;
    endtask

    // Issue one request (called just after a rising edge) and return in the cycle after RESP.
    task automatic txn(input logic [6:0] a, input logic [15:0] dt, input bit v,
                       input int dw, input int dr, input logic [15:0] rv, output int acc);
        dly_wr = dw;
        dly_rd = dr;
        rd_val = rv;
        req_addr = a;
        req_data = dt;
        req_verify = v;
        req_valid = 1'b1;
        acc = cyc;
        model_start(a, dt, v, dw, dr, rv);
        // Junk requests while busy must not disturb the access in flight.
        @(posedge clk); #1;
        req_addr = ~a;
        req_data = ~dt;
        req_verify = ~v;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        while (cyc <= m_resp) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int acc;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", busy_w[0], 0);
        chk("reset req_ready", req_ready_w[0], 0);
        rstn = 1'b1;
        #1;
        chk("release req_ready", req_ready_w[0], 1);
        chk("release busy", busy_w[0], 0);
        @(posedge clk); #1;

        txn(7'h41, 16'h2000, 1'b0, 3, 0, 16'h0000, acc);
        chk("wr41 latency", last_resp[0] - acc, 5);
        chk("wr41 status", last_st[0], 2'b00);
        chk("wr41 rdata", last_rd[0], 16'h0000);

        txn(7'h40, 16'h1234, 1'b0, 1, 0, 16'h0000, acc);
        chk("fast latency", last_resp[0] - acc, 3);

        txn(7'h49, 16'h0F0F, 1'b1, 2, 2, 16'h0F0F, acc);
        chk("verify latency", last_resp[0] - acc, 7);
        chk("verify status", last_st[0], 2'b00);
        chk("verify rdata", last_rd[0], 16'h0F0F);

        txn(7'h49, 16'h0F0F, 1'b1, 1, 1, 16'h0F0E, acc);
        chk("mismatch status mask FFFF", last_st[0], 2'b10);
        chk("mismatch status mask FFFE", last_st[1], 2'b00);
        chk("mismatch rdata", last_rd[0], 16'h0F0E);

        txn(7'h4A, 16'h0001, 1'b0, NEVER, 0, 16'h0000, acc);
        chk("timeout latency", last_resp[0] - acc, 10);
        chk("timeout status", last_st[0], 2'b01);

        txn(7'h4B, 16'h0002, 1'b0, TO, 0, 16'h0000, acc);
        chk("drdy at limit status", last_st[0], 2'b00);
        chk("drdy at limit latency", last_resp[0] - acc, 10);

        txn(7'h4C, 16'h0003, 1'b0, TO + 1, 0, 16'h0000, acc);
        chk("drdy late status", last_st[0], 2'b01);

        txn(7'h4D, 16'h5555, 1'b1, 1, NEVER, 16'h5555, acc);
        chk("read timeout status", last_st[0], 2'b01);
        chk("read timeout rdata", last_rd[0], 16'h0000);
        chk("read timeout latency", last_resp[0] - acc, 12);

        txn(7'h4E, 16'h1357, 1'b1, 1, TO, 16'h1357, acc);
        chk("read at limit status", last_st[0], 2'b00);
        chk("read at limit rdata", last_rd[0], 16'h1357);

        // Reset during WR_WAIT; the pending drdy lands in IDLE after release.
        dly_wr = 6;
        req_addr = 7'h50;
        req_data = 16'hABCD;
        req_verify = 1'b0;
        req_valid = 1'b1;
        model_start(7'h50, 16'hABCD, 1'b0, 6, 0, 16'h0000);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rstn = 1'b0;
        act = 1'b0;
        #1;
        chk("midop reset busy", busy_w[0], 0);
        chk("midop reset den", den_w[0], 0);
        chk("midop reset daddr", daddr_w[0], 7'h00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        txn(7'h41, 16'h00FF, 1'b0, 2, 0, 16'h0000, acc);
        chk("post reset latency", last_resp[0] - acc, 4);
        chk("post reset status", last_st[0], 2'b00);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
